// File: rtl/bk_pkg.sv
// bk_pkg: shared datapath width and prefix-node type for the Brent-Kung subtractor.
package bk_pkg;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Prefix operator: combine a group with the adjacent less-significant group.
    function automatic pg_t pg_dot(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction
endpackage

// File: rtl/bk_sub16_pipe_if.sv
// bk_sub16_pipe_if: operand/result valid-ready bundle for bk_sub16_pipe.
interface bk_sub16_pipe_if;
    import bk_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/bk_prefix16.sv
// bk_prefix16: combinational completion of a 16-bit Brent-Kung carry tree.
// g/p arrive in Brent-Kung in-place form (odd indices already hold 2-bit groups, i%4==3 hold 4-bit groups).
module bk_prefix16
    import bk_pkg::*;
(
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic             cin,
    output logic [WIDTH:0]   c
);
    pg_t node [WIDTH];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) node[i] = '{p: p[i], g: g[i]};
        // up-sweep: 8-bit groups, then the full 16-bit group
        for (int i = 7; i < WIDTH; i += 8) node[i] = pg_dot(node[i], node[i-4]);
        node[15] = pg_dot(node[15], node[7]);
        // down-sweep: spread prefixes back to every remaining index
        node[11] = pg_dot(node[11], node[7]);
        for (int i = 5; i < WIDTH; i += 4) node[i] = pg_dot(node[i], node[i-2]);
        for (int i = 2; i < WIDTH; i += 2) node[i] = pg_dot(node[i], node[i-1]);

        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) c[i+1] = node[i].g | (node[i].p & cin);
    end
endmodule

// File: rtl/bk_sub16_pipe.sv
// bk_sub16_pipe: 2-stage valid/ready 16-bit subtractor, diff = a - b - bin via a Brent-Kung tree.
// Optional BK_SUB_SAT_EN clamps diff to zero whenever the subtraction borrows.
module bk_sub16_pipe
    import bk_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    bk_sub16_pipe_if.slave    io
);
    logic             accept, s2_adv, load2;
    logic [WIDTH-1:0] bit_p, bit_g, grp_p, grp_g;
    pg_t              up [WIDTH];

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_p_q, s1_p_d;
    logic [WIDTH-1:0] s1_gp_q, s1_gp_d;
    logic [WIDTH-1:0] s1_gg_q, s1_gg_d;
    logic             s1_cin_q, s1_cin_d;
    logic             s1_a_msb_q, s1_a_msb_d;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum, res;
    logic             borrow, ovf_c;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_diff_q, s2_diff_d;
    logic             s2_bout_q, s2_bout_d;
    logic             s2_ovf_q, s2_ovf_d;

    assign s2_adv      = !s2_valid_q | io.out_ready;
    assign io.in_ready = !rst & (!s1_valid_q | !s2_valid_q | io.out_ready);
    assign accept      = io.in_valid & io.in_ready;

    // S1: a + ~b + ~bin, first two up-sweep levels kept in place
    always_comb begin
        bit_p = io.a ^ ~io.b;
        bit_g = io.a & ~io.b;
        for (int i = 0; i < WIDTH; i++) up[i] = '{p: bit_p[i], g: bit_g[i]};
        for (int i = 1; i < WIDTH; i += 2) up[i] = pg_dot(up[i], up[i-1]);
        for (int i = 3; i < WIDTH; i += 4) up[i] = pg_dot(up[i], up[i-2]);
        for (int i = 0; i < WIDTH; i++) begin
            grp_p[i] = up[i].p;
            grp_g[i] = up[i].g;
        end

        s1_valid_d = accept | (s1_valid_q & !s2_adv);
        s1_p_d     = accept ? bit_p       : s1_p_q;
        s1_gp_d    = accept ? grp_p       : s1_gp_q;
        s1_gg_d    = accept ? grp_g       : s1_gg_q;
        s1_cin_d   = accept ? ~io.bin     : s1_cin_q;
        s1_a_msb_d = accept ? io.a[WIDTH-1] : s1_a_msb_q;
    end

    bk_prefix16 u_prefix (
        .g   (s1_gg_q),
        .p   (s1_gp_q),
        .cin (s1_cin_q),
        .c   (carry)
    );

    // S2: operands differ in sign exactly when the bitwise propagate of the MSB is 0
    always_comb begin
        sum    = s1_p_q ^ carry[WIDTH-1:0];
        borrow = ~carry[WIDTH];
        ovf_c  = ~s1_p_q[WIDTH-1] & (sum[WIDTH-1] ^ s1_a_msb_q);
`ifdef BK_SUB_SAT_EN
        res    = borrow ? '0 : sum;
`else
        res    = sum;
`endif
        load2      = s2_adv & s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_diff_d  = load2 ? res    : s2_diff_q;
        s2_bout_d  = load2 ? borrow : s2_bout_q;
        s2_ovf_d   = load2 ? ovf_c  : s2_ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_gp_q    <= '0;
            s1_gg_q    <= '0;
            s1_cin_q   <= 1'b0;
            s1_a_msb_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_diff_q  <= '0;
            s2_bout_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_p_q     <= s1_p_d;
            s1_gp_q    <= s1_gp_d;
            s1_gg_q    <= s1_gg_d;
            s1_cin_q   <= s1_cin_d;
            s1_a_msb_q <= s1_a_msb_d;
            s2_valid_q <= s2_valid_d;
            s2_diff_q  <= s2_diff_d;
            s2_bout_q  <= s2_bout_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign io.out_valid = s2_valid_q;
    assign io.diff      = s2_diff_q;
    assign io.bout      = s2_bout_q;
    assign io.ovf       = s2_ovf_q;
endmodule

// File: tb/tb_bk_sub16_pipe.sv
// tb_bk_sub16_pipe: directed vectors, stall/reset sequences and a random soak for bk_sub16_pipe.
module tb_bk_sub16_pipe;
`ifdef BK_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bk_sub16_pipe_if bus ();
    bk_sub16_pipe dut (.clk(clk), .rst(rst), .io(bus));

    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic [17:0] exp_q [$];
    bit          rand_or = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference: {ovf, bout, diff}
    function automatic logic [17:0] model(input logic [15:0] a_i, input logic [15:0] b_i, input logic bin_i);
        logic [16:0] full;
        logic [15:0] d;
        logic        o;
        full = {1'b0, a_i} - {1'b0, b_i} - {16'd0, bin_i};
        d    = full[15:0];
        o    = (a_i[15] != b_i[15]) && (d[15] != a_i[15]);
        if (SAT && full[16]) d = 16'h0000;
        return {o, full[16], d};
    endfunction

    function automatic logic [17:0] obs_res();
        return {bus.ovf, bus.bout, bus.diff};
    endfunction

    // result scoreboard and hold-stability monitor, sampled mid-cycle
    initial begin : monitor
        logic        held;
        logic [17:0] held_val;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held && bus.out_valid) chk("hold_stable", 32'(obs_res()), 32'(held_val));
                held     = bus.out_valid && !bus.out_ready;
                held_val = obs_res();
                if (bus.out_valid && bus.out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) chk("spurious_result", 32'(bus.out_valid), 32'(0));
                    else chk("result", 32'(obs_res()), 32'(exp_q.pop_front()));
                end
                if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.bin));
            end
        end
    end

    task automatic send(input logic [15:0] a_i, input logic [15:0] b_i, input logic bin_i, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        bus.a = a_i;
        bus.b = b_i;
        bus.bin = bin_i;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (!acc) waits++;
            @(posedge clk);
            #1;
            if (rand_or) bus.out_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'(1));
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    logic [15:0] va [8] = '{16'h0005, 16'h0000, 16'h8000, 16'hFFFF, 16'h1234, 16'h0000, 16'h7FFF, 16'h1000};
    logic [15:0] vb [8] = '{16'h0003, 16'h0001, 16'h0001, 16'hFFFF, 16'h1234, 16'h0000, 16'hFFFF, 16'h0FFF};
    logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] vd [8] = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h8000, 16'h0000};
    logic        vbo[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vov[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int          w;
        int          n0;
        int          stale;
        logic [15:0] ra, rb;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;

        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_outputs", 32'(obs_res()), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;

        // directed vectors, single beat each, latency 2
        for (int v = 0; v < 8; v++) begin
            send(va[v], vb[v], vc[v], w);
            bus.in_valid = 1'b0;
            chk("vec_accept_wait", 32'(w), 32'(0));
            @(negedge clk);
            chk("vec_lat1_valid", 32'(bus.out_valid), 32'(0));
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("vec_lat2_valid", 32'(bus.out_valid), 32'(1));
            chk("vec_diff", 32'(bus.diff), 32'((SAT && vbo[v]) ? 16'h0000 : vd[v]));
            chk("vec_bout", 32'(bus.bout), 32'(vbo[v]));
            chk("vec_ovf", 32'(bus.ovf), 32'(vov[v]));
            @(posedge clk);
            #1;
        end
        drain();

        // back-pressure: 2 accepts then in_ready drops, head result held
        bus.out_ready = 1'b0;
        send(16'h0010, 16'h0001, 1'b0, w);
        chk("stall_acc0_wait", 32'(w), 32'(0));
        send(16'h0100, 16'h0001, 1'b1, w);
        chk("stall_acc1_wait", 32'(w), 32'(0));
        bus.a = 16'h0003;
        bus.b = 16'h0005;
        bus.bin = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(bus.in_ready), 32'(0));
            chk("stall_out_valid", 32'(bus.out_valid), 32'(1));
            chk("stall_head_diff", 32'(bus.diff), 32'(16'h000F));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        n0 = n_out;
        send(16'h0003, 16'h0005, 1'b0, w);
        chk("stall_acc2_wait", 32'(w), 32'(0));
        send(16'hAAAA, 16'h5555, 1'b0, w);
        bus.in_valid = 1'b0;
        drain();
        chk("stall_result_count", 32'(n_out - n0), 32'(4));

        // reset with two beats in flight
        bus.out_ready = 1'b0;
        send(16'h1111, 16'h0001, 1'b0, w);
        send(16'h2222, 16'h0002, 1'b0, w);
        bus.in_valid = 1'b0;
        chk("flight_out_valid", 32'(bus.out_valid), 32'(1));
        chk("flight_in_ready", 32'(bus.in_ready), 32'(0));
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("midrst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("midrst_diff", 32'(bus.diff), 32'(0));
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'(1));
        bus.out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("stale_results", 32'(stale), 32'(0));
        @(posedge clk);
        #1;

        // random soak with random back-pressure
        n0 = n_out;
        rand_or = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = ra;
                1:       rb = ra + 16'h0001;
                2:       rb = 16'h8000;
                default: rb = 16'($urandom);
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)), w);
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
        bus.in_valid = 1'b0;
        rand_or = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("random_result_count", 32'(n_out - n0), 32'(10000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
